// File: rtl/ppu.sv
// PPU register front end: raster counters, CPU clock-enable divider, VBlank/NMI,
// the 0x2000-0x3FFF register file with VRAM/OAM access ports, PRG pass-through
// and the 0x4014 OAM DMA engine. The renderer fetch ports are tied off.
module ppu #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int V_BLANK = 480
) (
    input  logic        clock25,
    input  logic        reset_n,
    output logic        ce_cpu,
    output logic        nmi,
    input  logic [15:0] cpu_a,
    output logic [7:0]  cpu_i,
    input  logic [7:0]  cpu_o,
    input  logic        cpu_r,
    input  logic        cpu_w,
    output logic [15:0] prga,
    output logic [7:0]  prgd,
    output logic        prgw,
    input  logic [7:0]  prgi,
    output logic [14:0] vida,
    output logic [7:0]  vido,
    output logic        vidw,
    input  logic [7:0]  vidi,
    output logic [7:0]  oam2a,
    output logic [7:0]  oam2o,
    output logic        oam2w,
    input  logic [7:0]  oam2i,
    output logic [14:0] chra,
    input  logic [7:0]  chrd,
    output logic [7:0]  oama,
    input  logic [7:0]  oamd
);

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] Y_BLANK  = 10'(V_BLANK);
    localparam logic [3:0] DIV_LAST = 4'd13;

    // reset_n is active-high despite its name
    logic rst;
    assign rst = reset_n;

    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [3:0]  div_q, div_d;
    logic [7:0]  ctrl_q, ctrl_d, mask_q, mask_d;
    logic [7:0]  scroll_x_q, scroll_x_d, scroll_y_q, scroll_y_d;
    logic [7:0]  oamaddr_q, oamaddr_d, rdbuf_q, rdbuf_d;
    logic [13:0] v_q, v_d;
    logic        w_q, w_d, vbl_q, vbl_d;
    logic        dma_act_q, dma_act_d;
    logic [7:0]  dma_page_q, dma_page_d;
    logic [8:0]  dma_cnt_q, dma_cnt_d;

    logic        ppu_sel, dma_sel, ce, wr_ppu, rd_ppu, dma_start, dma_phase;
    logic [2:0]  reg_sel;
    logic [7:0]  dma_idx;
    logic [13:0] v_inc;

    assign ppu_sel   = (cpu_a[15:13] == 3'b001);
    assign dma_sel   = (cpu_a == 16'h4014);
    assign reg_sel   = cpu_a[2:0];
    assign ce        = !rst && (div_q == DIV_LAST) && !dma_act_q;
    assign wr_ppu    = ce && cpu_w && ppu_sel;
    assign rd_ppu    = ce && cpu_r && ppu_sel;
    assign dma_start = ce && cpu_w && dma_sel && !dma_act_q;
    // DMA counter: bit 0 selects fetch (0) or OAM store (1), upper bits are the byte index
    assign dma_idx   = dma_cnt_q[8:1];
    assign dma_phase = dma_cnt_q[0];
    assign v_inc     = ctrl_q[2] ? 14'd32 : 14'd1;

    // Next-state logic for counters, register file, VBlank and DMA
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        div_d      = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        ctrl_d     = ctrl_q;
        mask_d     = mask_q;
        scroll_x_d = scroll_x_q;
        scroll_y_d = scroll_y_q;
        oamaddr_d  = oamaddr_q;
        rdbuf_d    = rdbuf_q;
        v_d        = v_q;
        w_d        = w_q;
        vbl_d      = vbl_q;
        dma_act_d  = dma_act_q;
        dma_page_d = dma_page_q;
        dma_cnt_d  = dma_cnt_q;

        if (x_q == X_LAST) begin
            x_d = 10'd0;
            y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
        end else begin
            x_d = x_q + 10'd1;
        end

        if (wr_ppu) begin
            case (reg_sel)
                3'd0: ctrl_d = cpu_o;
                3'd1: mask_d = cpu_o;
                3'd3: oamaddr_d = cpu_o;
                3'd4: oamaddr_d = oamaddr_q + 8'd1;
                3'd5: begin
                    if (!w_q) scroll_x_d = cpu_o;
                    else      scroll_y_d = cpu_o;
                    w_d = !w_q;
                end
                3'd6: begin
                    if (!w_q) v_d[13:8] = cpu_o[5:0];
                    else      v_d[7:0]  = cpu_o;
                    w_d = !w_q;
                end
                3'd7: v_d = v_q + v_inc;
                default: ;
            endcase
        end

        if (rd_ppu) begin
            case (reg_sel)
                3'd2: begin
                    vbl_d = 1'b0;
                    w_d   = 1'b0;
                end
                3'd7: begin
                    rdbuf_d = vidi;
                    v_d     = v_q + v_inc;
                end
                default: ;
            endcase
        end

        // flag tracks the position the counters are about to enter
        if ((x_d == 10'd0) && (y_d == Y_BLANK)) vbl_d = 1'b1;
        else if ((x_d == 10'd0) && (y_d == 10'd0)) vbl_d = 1'b0;

        if (dma_start) begin
            dma_act_d  = 1'b1;
            dma_page_d = cpu_o;
            dma_cnt_d  = 9'd0;
        end else if (dma_act_q) begin
            dma_cnt_d = dma_cnt_q + 9'd1;
            if (dma_cnt_q == 9'd511) dma_act_d = 1'b0;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clock25 or posedge reset_n) begin
        if (reset_n) begin
            x_q        <= '0;
            y_q        <= '0;
            div_q      <= '0;
            ctrl_q     <= '0;
            mask_q     <= '0;
            scroll_x_q <= '0;
            scroll_y_q <= '0;
            oamaddr_q  <= '0;
            rdbuf_q    <= '0;
            v_q        <= '0;
            w_q        <= 1'b0;
            vbl_q      <= 1'b0;
            dma_act_q  <= 1'b0;
            dma_page_q <= '0;
            dma_cnt_q  <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            div_q      <= div_d;
            ctrl_q     <= ctrl_d;
            mask_q     <= mask_d;
            scroll_x_q <= scroll_x_d;
            scroll_y_q <= scroll_y_d;
            oamaddr_q  <= oamaddr_d;
            rdbuf_q    <= rdbuf_d;
            v_q        <= v_d;
            w_q        <= w_d;
            vbl_q      <= vbl_d;
            dma_act_q  <= dma_act_d;
            dma_page_q <= dma_page_d;
            dma_cnt_q  <= dma_cnt_d;
        end
    end

    // Output muxing; everything is held at zero while reset is asserted
    always_comb begin
        ce_cpu = 1'b0;
        nmi    = 1'b0;
        cpu_i  = 8'h00;
        prga   = 16'h0000;
        prgd   = 8'h00;
        prgw   = 1'b0;
        vida   = 15'h0000;
        vido   = 8'h00;
        vidw   = 1'b0;
        oam2a  = 8'h00;
        oam2o  = 8'h00;
        oam2w  = 1'b0;
        chra   = 15'h0000;
        oama   = 8'h00;
        if (!rst) begin
            ce_cpu = ce;
            nmi    = vbl_q & ctrl_q[7];
            vida   = {1'b0, v_q};
            vido   = cpu_o;
            vidw   = wr_ppu && (reg_sel == 3'd7);
            if (dma_act_q) begin
                prga  = {dma_page_q, dma_idx};
                oam2a = oamaddr_q + dma_idx;
                oam2o = prgi;
                oam2w = dma_phase;
            end else begin
                prga  = cpu_a;
                prgd  = cpu_o;
                prgw  = cpu_w && !ppu_sel && !dma_sel;
                oam2a = oamaddr_q;
                oam2o = cpu_o;
                oam2w = wr_ppu && (reg_sel == 3'd4);
            end
            if (ppu_sel) begin
                case (reg_sel)
                    3'd2:    cpu_i = {vbl_q, 7'b0};
                    3'd4:    cpu_i = oam2i;
                    3'd7:    cpu_i = rdbuf_q;
                    default: cpu_i = 8'h00;
                endcase
            end else begin
                cpu_i = prgi;
            end
        end
    end

    // Renderer inputs and not-yet-consumed registers
    logic unused_sink;
    assign unused_sink = ^{chrd, oamd, mask_q, scroll_x_q, scroll_y_q};

endmodule

// File: tb/tb_ppu.sv
// Directed bench for ppu: reduced raster (40 x 12, VBlank on line 8) so a
// frame is 480 clocks; synchronous PRG/VRAM/OAM memory models.
module tb_ppu;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        ce_cpu, nmi;
    logic [15:0] cpu_a = 16'h0;
    logic [7:0]  cpu_i;
    logic [7:0]  cpu_o = 8'h0;
    logic        cpu_r = 1'b0, cpu_w = 1'b0;
    logic [15:0] prga;
    logic [7:0]  prgd, prgi;
    logic        prgw;
    logic [14:0] vida;
    logic [7:0]  vido, vidi;
    logic        vidw;
    logic [7:0]  oam2a, oam2o, oam2i;
    logic        oam2w;
    logic [14:0] chra;
    logic [7:0]  chrd = 8'h5C;
    logic [7:0]  oama;
    logic [7:0]  oamd = 8'hC5;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc;
    int vidw_cnt = 0;

    logic [7:0] prg_mem [0:65535];
    logic [7:0] vram    [0:32767];
    logic [7:0] oam_mem [0:255];

    ppu #(.H_TOTAL(40), .V_TOTAL(12), .V_BLANK(8)) dut (
        .clock25(clk), .reset_n(reset_n), .ce_cpu(ce_cpu), .nmi(nmi),
        .cpu_a(cpu_a), .cpu_i(cpu_i), .cpu_o(cpu_o), .cpu_r(cpu_r), .cpu_w(cpu_w),
        .prga(prga), .prgd(prgd), .prgw(prgw), .prgi(prgi),
        .vida(vida), .vido(vido), .vidw(vidw), .vidi(vidi),
        .oam2a(oam2a), .oam2o(oam2o), .oam2w(oam2w), .oam2i(oam2i),
        .chra(chra), .chrd(chrd), .oama(oama), .oamd(oamd)
    );

    always #20 clk = ~clk;

    // Memories; PRG page 0x02 reads back its own low address byte
    always @(posedge clk) begin
        prgi  <= (prga[15:8] == 8'h02) ? prga[7:0] : prg_mem[prga];
        if (prgw) prg_mem[prga] <= prgd;
        vidi  <= vram[vida];
        if (vidw) vram[vida] <= vido;
        oam2i <= oam_mem[oam2a];
        if (oam2w) oam_mem[oam2a] <= oam2o;
        if (vidw) vidw_cnt <= vidw_cnt + 1;
    end

    always @(posedge clk or posedge reset_n) begin
        if (reset_n) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic bus_begin(input logic [15:0] a, input logic [7:0] d, input logic w, input logic r);
        cpu_a = a; cpu_o = d; cpu_w = w; cpu_r = r;
    endtask

    task automatic wait_ce(output bit ok);
        ok = 1'b0;
        #1;
        for (int n = 0; n < 40; n++) begin
            if (ce_cpu) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL ce_timeout: got no ce_cpu, required one within 40 clocks");
        end
    endtask

    task automatic bus_end();
        @(posedge clk); #1;
        cpu_w = 1'b0; cpu_r = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        bit ok;
        bus_begin(a, d, 1'b1, 1'b0); wait_ce(ok); bus_end();
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        bit ok;
        bus_begin(a, 8'h00, 1'b0, 1'b1); wait_ce(ok); d = cpu_i; bus_end();
    endtask

    task automatic wait_phase(input int ph);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (cyc % 480 == ph) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL frame_timeout: phase %0d not reached", ph);
        end
    endtask

    task automatic test_reset();
        bus_begin(16'h0234, 8'hA5, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++; if ({ce_cpu, nmi, prgw, vidw, oam2w} !== 5'b0) begin n_fail++; $display("FAIL rst_strobes: got %b required 00000", {ce_cpu, nmi, prgw, vidw, oam2w}); end
        n_cmp++; if (prga !== 16'h0) begin n_fail++; $display("FAIL rst_prga: got %h required 0000", prga); end
        n_cmp++; if ({prgd, vido, oam2o, cpu_i} !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h required 0", {prgd, vido, oam2o, cpu_i}); end
        n_cmp++; if ({vida, oam2a, chra, oama} !== 46'h0) begin n_fail++; $display("FAIL rst_addr: got %h required 0", {vida, oam2a, chra, oama}); end
        bus_begin(16'h0000, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
    endtask

    task automatic test_ce_divider();
        int pulses, first, last, gap_err;
        pulses = 0; first = -1; last = 0; gap_err = 0;
        for (int c = 1; c <= 280; c++) begin
            @(negedge clk);
            if (ce_cpu) begin
                if (pulses == 0) first = c;
                else if (c - last != 14) gap_err++;
                last = c;
                pulses++;
            end
        end
        n_cmp++; if (pulses !== 20) begin n_fail++; $display("FAIL ce_count: got %0d required 20", pulses); end
        n_cmp++; if (first !== 13) begin n_fail++; $display("FAIL ce_first: got %0d required 13", first); end
        n_cmp++; if (gap_err !== 0) begin n_fail++; $display("FAIL ce_spacing: got %0d bad gaps required 0", gap_err); end
    endtask

    task automatic test_nmi();
        bit ok;
        logic [7:0] d;
        logic nmi_at_read;
        cpu_write(16'h2000, 8'h80);
        wait_phase(319);
        n_cmp++; if (nmi !== 1'b0) begin n_fail++; $display("FAIL nmi_before_vbl: got %b required 0", nmi); end
        @(negedge clk);
        n_cmp++; if (nmi !== 1'b1) begin n_fail++; $display("FAIL nmi_at_vbl: got %b required 1", nmi); end
        bus_begin(16'h2002, 8'h00, 1'b0, 1'b1); wait_ce(ok);
        d = cpu_i; nmi_at_read = nmi;
        bus_end();
        n_cmp++; if (d !== 8'h80) begin n_fail++; $display("FAIL status_read: got %h required 80", d); end
        n_cmp++; if (nmi_at_read !== 1'b1) begin n_fail++; $display("FAIL nmi_during_read: got %b required 1", nmi_at_read); end
        n_cmp++; if (nmi !== 1'b0) begin n_fail++; $display("FAIL nmi_after_read: got %b required 0", nmi); end
        wait_phase(320);
        n_cmp++; if (nmi !== 1'b1) begin n_fail++; $display("FAIL nmi_next_frame: got %b required 1", nmi); end
        wait_phase(479);
        n_cmp++; if (nmi !== 1'b1) begin n_fail++; $display("FAIL nmi_last_line: got %b required 1", nmi); end
        @(negedge clk);
        n_cmp++; if (nmi !== 1'b0) begin n_fail++; $display("FAIL vbl_clear_y0: got %b required 0", nmi); end
    endtask

    task automatic test_vram_write();
        bit ok;
        logic [7:0] d;
        int cnt0;
        cpu_write(16'h2006, 8'h3F);
        cpu_read(16'h2002, d);
        cpu_write(16'h200E, 8'h21);
        cpu_write(16'h2006, 8'h08);
        cnt0 = vidw_cnt;
        bus_begin(16'h2007, 8'h55, 1'b1, 1'b0); wait_ce(ok);
        n_cmp++; if ({vida, vido, vidw} !== {15'h2108, 8'h55, 1'b1}) begin n_fail++; $display("FAIL vram_wr_port: got %h/%h/%b required 2108/55/1", vida, vido, vidw); end
        bus_end();
        repeat (3) @(negedge clk);
        n_cmp++; if (vidw_cnt - cnt0 !== 1) begin n_fail++; $display("FAIL vidw_pulses: got %0d required 1", vidw_cnt - cnt0); end
        n_cmp++; if (vida !== 15'h2109) begin n_fail++; $display("FAIL v_after_wr: got %h required 2109", vida); end
        n_cmp++; if (vram[15'h2108] !== 8'h55) begin n_fail++; $display("FAIL vram_content: got %h required 55", vram[15'h2108]); end
    endtask

    task automatic test_read_buffer();
        logic [7:0] d0, d1, d2;
        cpu_write(16'h2000, 8'h04);
        cpu_write(16'h2006, 8'h20);
        cpu_write(16'h2006, 8'h00);
        cpu_write(16'h2007, 8'hC3);
        cpu_write(16'h2006, 8'h21);
        cpu_write(16'h2006, 8'h08);
        cpu_read(16'h2007, d0);
        cpu_write(16'h2006, 8'h20);
        cpu_write(16'h2006, 8'h00);
        cpu_read(16'h2007, d1);
        cpu_read(16'h3FFF, d2);
        n_cmp++; if (d0 !== 8'h00) begin n_fail++; $display("FAIL rdbuf_initial: got %h required 00", d0); end
        n_cmp++; if (d1 !== 8'h55) begin n_fail++; $display("FAIL rdbuf_stale: got %h required 55", d1); end
        n_cmp++; if (d2 !== 8'hC3) begin n_fail++; $display("FAIL rdbuf_vram: got %h required C3", d2); end
        n_cmp++; if (vida !== 15'h2040) begin n_fail++; $display("FAIL v_inc32: got %h required 2040", vida); end
    endtask

    task automatic test_oam_dma();
        bit ok;
        int ce_seen, wr_seen, addr_err, wr_err, bad;
        logic [7:0] idx;
        ce_seen = 0; wr_seen = 0; addr_err = 0; wr_err = 0; bad = 0;
        cpu_write(16'h2003, 8'h00);
        bus_begin(16'h4014, 8'h02, 1'b1, 1'b0); wait_ce(ok);
        n_cmp++; if (prgw !== 1'b0) begin n_fail++; $display("FAIL prgw_4014: got %b required 0", prgw); end
        bus_end();
        for (int n = 1; n <= 512; n++) begin
            @(negedge clk);
            idx = 8'((n - 1) >> 1);
            if (ce_cpu) ce_seen++;
            if (oam2w) wr_seen++;
            if (prga !== {8'h02, idx}) addr_err++;
            if (((n - 1) & 1) == 1) begin
                if ({oam2w, oam2a, oam2o} !== {1'b1, idx, idx}) wr_err++;
            end else if (oam2w !== 1'b0) begin
                wr_err++;
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) if (oam_mem[i] !== 8'(i)) bad++;
        n_cmp++; if (ce_seen !== 0) begin n_fail++; $display("FAIL dma_ce_low: got %0d pulses required 0", ce_seen); end
        n_cmp++; if (wr_seen !== 256) begin n_fail++; $display("FAIL dma_oam2w: got %0d pulses required 256", wr_seen); end
        n_cmp++; if (addr_err !== 0) begin n_fail++; $display("FAIL dma_prga: got %0d bad cycles required 0", addr_err); end
        n_cmp++; if (wr_err !== 0) begin n_fail++; $display("FAIL dma_store: got %0d bad cycles required 0", wr_err); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL dma_oam_data: got %0d wrong bytes required 0", bad); end
        n_cmp++; if (oam2a !== 8'h00) begin n_fail++; $display("FAIL dma_oamaddr_kept: got %h required 00", oam2a); end
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ce_cpu) ok = 1'b1;
        end
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL dma_ce_resume: got %b required 1", ok); end
    endtask

    task automatic test_oam_port();
        bit ok;
        logic [7:0] d;
        bus_begin(16'h2004, 8'h99, 1'b1, 1'b0); wait_ce(ok);
        n_cmp++; if ({oam2a, oam2o, oam2w} !== {8'h00, 8'h99, 1'b1}) begin n_fail++; $display("FAIL oam_wr_port: got %h/%h/%b required 00/99/1", oam2a, oam2o, oam2w); end
        bus_end();
        n_cmp++; if (oam2a !== 8'h01) begin n_fail++; $display("FAIL oamaddr_inc: got %h required 01", oam2a); end
        cpu_read(16'h2004, d);
        n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL oam_read: got %h required 01", d); end
        cpu_write(16'h2003, 8'hFF);
        cpu_write(16'h2004, 8'h11);
        n_cmp++; if (oam2a !== 8'h00) begin n_fail++; $display("FAIL oamaddr_wrap: got %h required 00", oam2a); end
        n_cmp++; if (oam_mem[255] !== 8'h11) begin n_fail++; $display("FAIL oam_ff_data: got %h required 11", oam_mem[255]); end
    endtask

    task automatic test_prg_port();
        bit ok;
        logic [7:0] d;
        bus_begin(16'h0010, 8'hAA, 1'b1, 1'b0); wait_ce(ok);
        n_cmp++; if ({prgw, prga, prgd} !== {1'b1, 16'h0010, 8'hAA}) begin n_fail++; $display("FAIL prg_wr_port: got %b/%h/%h required 1/0010/AA", prgw, prga, prgd); end
        bus_end();
        bus_begin(16'h2000, 8'h00, 1'b1, 1'b0); wait_ce(ok);
        n_cmp++; if (prgw !== 1'b0) begin n_fail++; $display("FAIL prgw_ppu: got %b required 0", prgw); end
        bus_end();
        cpu_read(16'h0010, d);
        n_cmp++; if (d !== 8'hAA) begin n_fail++; $display("FAIL prg_read: got %h required AA", d); end
        cpu_read(16'h2001, d);
        n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL unused_reg_read: got %h required 00", d); end
    endtask

    task automatic test_reset_mid_dma();
        bit ok;
        int wr_seen, ce_seen;
        wr_seen = 0; ce_seen = 0;
        bus_begin(16'h4014, 8'h02, 1'b1, 1'b0); wait_ce(ok); bus_end();
        repeat (20) @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_cmp++; if ({oam2w, ce_cpu, prga} !== 18'h0) begin n_fail++; $display("FAIL rst_dma_outputs: got %b/%b/%h required 0/0/0000", oam2w, ce_cpu, prga); end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (oam2w) wr_seen++;
            if (ce_cpu) ce_seen++;
        end
        n_cmp++; if (wr_seen !== 0) begin n_fail++; $display("FAIL rst_dma_oam2w: got %0d pulses required 0", wr_seen); end
        n_cmp++; if (ce_seen !== 42) begin n_fail++; $display("FAIL rst_dma_ce: got %0d pulses required 42", ce_seen); end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        cpu_write(16'h2006, 8'h21);
        cpu_write(16'h2006, 8'h30);
        cpu_write(16'h2007, 8'h12);
        cpu_write(16'h2006, 8'h21);
        cpu_write(16'h2006, 8'h30);
        bus_begin(16'h2007, 8'h66, 1'b1, 1'b0); wait_ce(ok);
        n_cmp++; if (vidw !== 1'b1) begin n_fail++; $display("FAIL vidw_pre_reset: got %b required 1", vidw); end
        reset_n = 1'b1;
        #1;
        n_cmp++; if (vidw !== 1'b0) begin n_fail++; $display("FAIL vidw_in_reset: got %b required 0", vidw); end
        @(posedge clk); #1;
        n_cmp++; if (vram[15'h2130] !== 8'h12) begin n_fail++; $display("FAIL vram_kept: got %h required 12", vram[15'h2130]); end
        cpu_w = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ce_divider();
        test_nmi();
        test_vram_write();
        test_read_buffer();
        test_oam_dma();
        test_oam_port();
        test_prg_port();
        test_reset_mid_dma();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ppu.md
PPU -- requirements
Module: ppu

Interface
REQ-001 clock25  in  1  sole clock, 25 MHz, rising edge.
REQ-002 reset_n  in  1  asynchronous reset, active-high (1 = reset).
REQ-003 ce_cpu  out  1  one-clock CPU clock-enable pulse.
REQ-004 nmi  out  1  NMI request to CPU, level, active-high.
REQ-005 cpu_a  in  16  CPU address.
REQ-006 cpu_i  out  8  read data to CPU.
REQ-007 cpu_o  in  8  write data from CPU.
REQ-008 cpu_r, cpu_w  in  1 each  CPU read / write strobes.
REQ-009 prga out 16, prgd out 8, prgw out 1, prgi in 8  PRG memory port.
REQ-010 vida out 15, vido out 8, vidw out 1, vidi in 8  VRAM port.
REQ-011 oam2a out 8, oam2o out 8, oam2w out 1, oam2i in 8  OAM read/write port.
REQ-012 chra out 15, chrd in 8; oama out 8, oamd in 8  renderer fetch ports; chra = 0 and oama = 0 in this revision; chrd and oamd are ignored.
REQ-013 All external memories are synchronous: read data is valid one clock25 edge after the address is presented.

Function
REQ-014 Counters: x 0..799 and y 0..524; x wraps to 0 and y increments; y wraps 524 -> 0.
REQ-015 ce_cpu pulses high for one clock every 14 clocks (divider 0..13, pulse at 13); it is forced low during OAM DMA.
REQ-016 VBlank flag (STATUS bit 7) is set at x=0, y=480 and cleared at x=0, y=0.
REQ-017 nmi = VBlank flag AND CTRL bit 7.
REQ-018 PPU registers decode at cpu_a 0x2000-0x3FFF, mirrored every 8 bytes (cpu_a[2:0]).
REQ-019 Register side effects occur only on clock edges where ce_cpu=1, once per CPU cycle.
REQ-020 Write 0x2000 -> CTRL; write 0x2001 -> MASK; write 0x2003 -> OAMADDR.
REQ-021 Write 0x2005: first write sets scroll X, second write sets scroll Y; shared write toggle w.
REQ-022 Write 0x2006: first write sets VRAM address v[13:8] = cpu_o[5:0]; second write sets v[7:0]; uses toggle w.
REQ-023 Write 0x2007: vida = {0, v}, vido = cpu_o, vidw high for one clock; then v += (CTRL bit 2 ? 32 : 1), modulo 2^14.
REQ-024 Read 0x2007: cpu_i = read buffer; buffer <= vidi; v increments as in REQ-023.
REQ-025 Read 0x2002: cpu_i = {VBlank, 7'b0}; the ce_cpu edge clears VBlank and w.
REQ-026 Write 0x2004: oam2a = OAMADDR, oam2o = cpu_o, oam2w high for one clock; OAMADDR += 1, wrapping 255 -> 0.
REQ-027 Read 0x2004: cpu_i = oam2i, with oam2a = OAMADDR.
REQ-028 Reads of other PPU registers return 0.
REQ-029 Non-PPU addresses: prga = cpu_a, prgd = cpu_o, prgw = cpu_w, cpu_i = prgi.
REQ-030 prgw is 0 for addresses 0x2000-0x3FFF and for 0x4014.
REQ-031 Write 0x4014 starts OAM DMA of page P = cpu_o.
DMA sequencing, for i = 0..255:
- prga = {P, i};
- next clock: oam2a = OAMADDR + i, oam2o = prgi, oam2w = 1;
- 2 clocks per byte, 512 clocks total.
After DMA, ce_cpu resumes; OAMADDR is unchanged.
REQ-032 A write to 0x4014 during an active DMA is ignored.

Reset
REQ-033 On reset_n=1, these are cleared to 0 immediately:
- all outputs;
- CTRL, MASK, scroll registers, OAMADDR, v, w, read buffer, VBlank, DMA state;
- x, y and the ce_cpu divider.
REQ-034 Reset asserted mid-DMA aborts the DMA with no further oam2w pulses; reset mid-write suppresses vidw.

Verification
REQ-035 Run from reset for 280 clocks -> exactly 20 ce_cpu pulses, each 14 clocks apart.
REQ-036 CTRL=0x80, run to x=0, y=480 -> nmi=1; then read 0x2002 -> returns 0x80, nmi falls to 0 the next clock.
REQ-037 Write 0x2006=0x21, 0x2006=0x08, 0x2007=0x55 -> vida=0x2108, vido=0x55, one vidw pulse; v becomes 0x2109.
REQ-038 CTRL=0x04, v=0x2000, two 0x2007 reads -> v becomes 0x2040; the first read returns the stale buffer; the second returns VRAM[0x2000].
REQ-039 OAMADDR=0, write 0x4014=0x02 with PRG[0x0200+i]=i -> 256 oam2w pulses, OAM[i]=i, no ce_cpu for 512 clocks.
REQ-040 Write 0x0010=0xAA -> prgw=1, prga=0x0010; write 0x2000 -> prgw=0.
